// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, FSM encoding and buffer entry layout.
package fetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          FIFO_ENTRIES     = 2;
   localparam logic [31:0] INSN_NOP         = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_FLUSH = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, insn} instruction buffer with occupancy count and synchronous clear.
module fetch_fifo
   import fetch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        push,
   input  logic        pop,
   input  logic [63:0] wr_data,
   output logic [63:0] rd_data,
   output logic [1:0]  count
);

   logic [63:0] mem [FIFO_ENTRIES];
   logic        wr_ptr;
   logic        rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'd2) || do_pop);
   assign rd_data = mem[rd_ptr];

   // NOTE: the storage array is reset as well, so the head reads as zero straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (clear) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and feeds decode from a 2-entry buffer.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = FIFO_ENTRIES
)(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        insn_valid,
   input  logic        insn_ready,
   output logic [31:0] insn,
   output logic [31:0] insn_pc
);

   localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

   fetch_state_t state;
   fetch_state_t state_nxt;
   logic [31:0]  pc;
   logic [31:0]  pc_nxt;
   logic [31:0]  flush_addr;
   logic [31:0]  flush_addr_nxt;
   logic [1:0]   count;
   logic [63:0]  head;
   logic         outstanding;
   logic         push;
   logic         pop;
   logic [2:0]   occ_after;

   assign outstanding = (state == ST_REQ) || (state == ST_FLUSH);
   assign imem_req    = outstanding;
   // In FLUSH the old request stays on the bus while pc already holds the redirect target.
   assign imem_addr   = (state == ST_FLUSH) ? flush_addr : pc;

   assign insn_valid  = (count != 2'd0);
   assign push        = (state == ST_REQ) && imem_ack && !redirect_valid;
   assign pop         = insn_valid && insn_ready && !redirect_valid;
   assign occ_after   = {1'b0, count} + {2'b00, push} - {2'b00, pop};
   assign {insn_pc, insn} = head;

   fetch_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear   (redirect_valid),
      .push    (push),
      .pop     (pop),
      .wr_data ({pc, imem_rdata}),
      .rd_data (head),
      .count   (count)
   );

   // NOTE: every signal written here gets its default first so no latch can be inferred.
   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      flush_addr_nxt = flush_addr;
      if (redirect_valid) begin
         pc_nxt = redirect_pc & ~32'h3;
         if (outstanding && !imem_ack) begin
            state_nxt = ST_FLUSH;
            if (state == ST_REQ) begin
               flush_addr_nxt = pc;
            end
         end else begin
            state_nxt = ST_REQ;
         end
      end else begin
         case (state)
            ST_IDLE:  state_nxt = ST_REQ;
            ST_REQ: begin
               if (imem_ack) begin
                  pc_nxt    = pc + 32'd4;
                  state_nxt = (occ_after < DEPTH) ? ST_REQ : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (occ_after < DEPTH) begin
                  state_nxt = ST_REQ;
               end
            end
            ST_FLUSH: begin
               if (imem_ack) begin
                  state_nxt = ST_REQ;
               end
            end
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         pc         <= RESET_PC;
         flush_addr <= RESET_PC;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         flush_addr <= flush_addr_nxt;
      end
   end

endmodule
